// File: rtl/ann_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ann_pkg
//  Purpose  : Shared constants, FSM state encoding, saturation helper and the
//             fixed Q8.8 weight/bias tables of the 8-8-4 classifier network.
//  Revision : 1.0 - initial release
// ============================================================================
package ann_pkg;

    localparam int NF     = 8;   // input features
    localparam int NH     = 8;   // hidden neurons
    localparam int NO     = 4;   // output neurons
    localparam int DW     = 16;  // data width
    localparam int FRAC   = 8;   // fractional bits (Q8.8)
    localparam int PROD_W = 32;  // product width
    localparam int ACC_W  = 40;  // accumulator width

    typedef logic signed [DW-1:0] q_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HID  = 2'd1,
        S_OUT  = 2'd2,
        S_ARG  = 2'd3
    } state_t;

    // Hidden layer weights, row = neuron, column = feature.
    localparam q_t W1 [0:NH-1][0:NF-1] = '{
        '{  64, -32,  16,  48, -16,  32,   8, -24},
        '{ -48,  80, -16,  24,  40,  -8,  16,  32},
        '{  32,  32, -64,  16,   8, -40,  56,  12},
        '{ -16, -24,  40, -72,  24,  16,  -8,  64},
        '{  96,  -8,  24, -16, -56,  40,  32, -48},
        '{   8,  56,  32, -24,  16, -96,  48,  20},
        '{ -64,  24,  -8,  72,  36,  12, -40,  28},
        '{  20, -36,  44,   8, -12,  60, -28,  52}
    };

    localparam q_t B1 [0:NH-1] = '{16, -32, 8, 64, -128, 24, 0, -8};

    // Output layer weights, row = output neuron, column = hidden neuron.
    localparam q_t W2 [0:NO-1][0:NH-1] = '{
        '{  64, -32,  48,  16, -24,  32,   8, -16},
        '{ -40,  72,  -8,  24,  56, -16,  32,  40},
        '{  24,  16,  64, -48,   8,  40, -24,  32},
        '{  48, -24,  16,  56, -32,   8,  64,  -8}
    };

    localparam q_t B2 [0:NO-1] = '{32, -16, 64, 0};

    // Clamp a wide signed value into the 16-bit signed range.
    function automatic q_t sat16(input logic signed [ACC_W-1:0] v);
        if (v > 40'sd32767) begin
            return 16'sh7fff;
        end else if (v < -40'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ann_mac.sv
`default_nettype none
// ============================================================================
//  Module   : ann_mac
//  Purpose  : Signed 16x16 multiply with 40-bit accumulate; the finalize path
//             adds the bias aligned to the product scale, shifts back to Q8.8
//             (arithmetic, floor) and saturates to 16 bits.
//  Revision : 1.0 - initial release
// ============================================================================
module ann_mac
    import ann_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    input  logic signed [DW-1:0] i_bias,
    output logic signed [DW-1:0] o_result
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    // Bias is Q8.8; products are Q16.16, so the bias is moved up by FRAC bits.
    assign w_bias_ext = {{(ACC_W-DW-FRAC){i_bias[DW-1]}}, i_bias, {FRAC{1'b0}}};
    assign w_sum      = r_acc + w_bias_ext;
    assign w_shift    = w_sum >>> FRAC;
    assign o_result   = sat16(w_shift);

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/top_ann_eda.sv
`default_nettype none
// ============================================================================
//  Module   : top_ann_eda
//  Purpose  : Sequential 8-8-4 fixed-point classifier. One shared MAC runs
//             8 multiply cycles plus 1 finalize cycle per neuron, hidden layer
//             first (with ReLU), then output layer, then an argmax cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module top_ann_eda
    import ann_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NF*DW-1:0] features,
    output logic             busy,
    output logic             done,
    output logic [NO*DW-1:0] output_layer,
    output logic [1:0]       predicted_class
);

    localparam logic [3:0] c_fin_idx  = 4'(NF);
    localparam logic [2:0] c_last_hid = 3'(NH-1);
    localparam logic [2:0] c_last_out = 3'(NO-1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_idx;
    logic [2:0]          r_neuron;
    logic [NF*DW-1:0]    r_feat;
    logic signed [DW-1:0] r_hidden [NH];
    logic signed [DW-1:0] r_scores [NO];
    logic [NO*DW-1:0]    r_output_layer;
    logic [1:0]          r_class;
    logic                r_done;

    logic                 w_accept;
    logic                 w_fin;
    logic                 w_layer;
    logic                 w_last;
    logic                 w_mac_clr;
    logic                 w_mac_en;
    logic signed [DW-1:0] w_a;
    logic signed [DW-1:0] w_b;
    logic signed [DW-1:0] w_bias;
    logic signed [DW-1:0] w_mac_result;
    logic signed [DW-1:0] w_relu;
    logic signed [DW-1:0] w_best;
    logic [1:0]           w_argmax;
    logic [NO*DW-1:0]     w_scores_packed;

    // A start landing in the done cycle is dropped even though the FSM is idle.
    assign w_accept  = (r_state == S_IDLE) && start && !r_done;
    assign w_fin     = (r_idx == c_fin_idx);
    assign w_layer   = (r_state == S_HID) || (r_state == S_OUT);
    assign w_last    = (r_state == S_HID) ? (r_neuron == c_last_hid)
                                          : (r_neuron == c_last_out);
    assign w_mac_clr = w_accept || (w_layer && w_fin);
    assign w_mac_en  = w_layer && !w_fin;
    assign w_relu    = w_mac_result[DW-1] ? '0 : w_mac_result;

    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign output_layer    = r_output_layer;
    assign predicted_class = r_class;

    ann_mac u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_mac_clr),
        .i_en     (w_mac_en),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_bias   (w_bias),
        .o_result (w_mac_result)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: each layer advances after its last neuron finalizes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)        w_next = S_HID;
            S_HID:   if (w_fin && w_last) w_next = S_OUT;
            S_OUT:   if (w_fin && w_last) w_next = S_ARG;
            S_ARG:                        w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    // MAC operand select: weight, activation and bias for the current step.
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_bias = '0;
        if (r_state == S_HID) begin
            w_a    = W1[r_neuron][r_idx[2:0]];
            w_b    = r_feat[{r_idx[2:0], 4'b0000} +: DW];
            w_bias = B1[r_neuron];
        end else if (r_state == S_OUT) begin
            w_a    = W2[r_neuron[1:0]][r_idx[2:0]];
            w_b    = r_hidden[r_idx[2:0]];
            w_bias = B2[r_neuron[1:0]];
        end
    end

    // Argmax with strict greater-than so the lowest index wins ties.
    always_comb begin
        w_best   = r_scores[0];
        w_argmax = 2'd0;
        for (int j = 1; j < NO; j++) begin
            if (r_scores[j] > w_best) begin
                w_best   = r_scores[j];
                w_argmax = 2'(j);
            end
        end
    end

    // Pack the score register file into the output bus layout.
    always_comb begin
        w_scores_packed = '0;
        for (int j = 0; j < NO; j++) begin
            w_scores_packed[j*DW +: DW] = r_scores[j];
        end
    end

    // Step and neuron counters for the layer sweeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_neuron <= '0;
        end else if (w_accept) begin
            r_idx    <= '0;
            r_neuron <= '0;
        end else if (w_layer) begin
            if (w_fin) begin
                r_idx    <= '0;
                r_neuron <= w_last ? 3'd0 : r_neuron + 3'd1;
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // Feature snapshot taken on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_feat <= '0;
        end else if (w_accept) begin
            r_feat <= features;
        end
    end

    // Neuron results written on each finalize cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NH; i++) r_hidden[i] <= '0;
            for (int j = 0; j < NO; j++) r_scores[j] <= '0;
        end else if (w_fin) begin
            if (r_state == S_HID) begin
                r_hidden[r_neuron] <= w_relu;
            end else if (r_state == S_OUT) begin
                r_scores[r_neuron[1:0]] <= w_mac_result;
            end
        end
    end

    // Visible results and the done pulse update together in ARG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_output_layer <= '0;
            r_class        <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_ARG) begin
                r_output_layer <= w_scores_packed;
                r_class        <= w_argmax;
                r_done         <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_top_ann_eda.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_top_ann_eda
//  Purpose  : Scoreboard bench for top_ann_eda with a bit-exact golden model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_top_ann_eda;
    import ann_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [NF*DW-1:0] features = '0;
    logic             busy;
    logic             done;
    logic [NO*DW-1:0] output_layer;
    logic [1:0]       predicted_class;

    top_ann_eda dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .features        (features),
        .busy            (busy),
        .done            (done),
        .output_layer    (output_layer),
        .predicted_class (predicted_class)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NO*DW-1:0] out;
        logic [1:0]       cls;
        int               done_cyc;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [NO*DW-1:0] last_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [NF*DW-1:0] pack8(input int v0, input int v1, input int v2, input int v3,
                                               input int v4, input int v5, input int v6, input int v7);
        return {16'(v7), 16'(v6), 16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    function automatic logic signed [DW-1:0] ref_sat(input longint acc);
        longint v;
        v = acc >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Golden model straight from the package tables.
    function automatic exp_t model(input logic [NF*DW-1:0] f);
        exp_t                 r;
        logic signed [DW-1:0] x [NF];
        logic signed [DW-1:0] h [NH];
        logic signed [DW-1:0] s [NO];
        longint               acc;
        int                   best;
        for (int i = 0; i < NF; i++) x[i] = f[i*DW +: DW];
        for (int n = 0; n < NH; n++) begin
            acc = longint'(B1[n]) * 256;
            for (int i = 0; i < NF; i++) acc += longint'(W1[n][i]) * longint'(x[i]);
            h[n] = ref_sat(acc);
            if (h[n] < 0) h[n] = 0;
        end
        r.out = '0;
        for (int o = 0; o < NO; o++) begin
            acc = longint'(B2[o]) * 256;
            for (int n = 0; n < NH; n++) acc += longint'(W2[o][n]) * longint'(h[n]);
            s[o] = ref_sat(acc);
            r.out[o*DW +: DW] = s[o];
        end
        best = 0;
        for (int o = 1; o < NO; o++) if (s[o] > s[best]) best = o;
        r.cls      = 2'(best);
        r.done_cyc = 0;
        return r;
    endfunction

    // Monitor: every done pulse pops one expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("output_layer", output_layer, e.out);
                    check("predicted_class", 64'(predicted_class), 64'(e.cls));
                    check("done_latency", 64'(cyc), 64'(e.done_cyc));
                end
            end
        end
    end

    // Pulse start for one cycle; when a result is expected, queue it.
    task automatic issue(input logic [NF*DW-1:0] f, input bit expect_done);
        exp_t e;
        @(negedge clk);
        features = f;
        start    = 1'b1;
        if (expect_done) begin
            e          = model(f);
            e.done_cyc = cyc + 110;
            last_out   = e.out;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic run(input logic [NF*DW-1:0] f);
        bit seen;
        issue(f, 1'b1);
        wait_done(200, seen);
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_output_layer"}, output_layer, 64'd0);
        check({tag, "_class"}, 64'(predicted_class), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector A, with the input bus scrambled after capture.
        issue(pack8(128, 64, 200, 100, 131, 90, 210, 84), 1'b1);
        features = pack8(-5000, 7000, -300, 12345, -32768, 32767, 1, -1);
        wait_done(200, seen);
        if (!seen) check("done_timeout_A", 64'd0, 64'd1);

        // Vector B, with a start pulse mid-run that must be ignored.
        issue(pack8(100, 120, 140, 160, 180, 200, 220, 240), 1'b1);
        repeat (30) @(negedge clk);
        features = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, seen);
        if (!seen) check("done_timeout_B", 64'd0, 64'd1);

        // Bias-only and saturation corners.
        run(pack8(0, 0, 0, 0, 0, 0, 0, 0));
        run(pack8(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767));

        // All -32768; start raised in the done cycle must be dropped.
        issue(pack8(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768), 1'b1);
        wait_done(200, seen);
        if (!seen) check("done_timeout_neg", 64'd0, 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_ignored", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("output_hold", output_layer, last_out);

        // Abort: reset around cycle 50 of a run.
        issue(pack8(128, 64, 200, 100, 131, 90, 210, 84), 1'b0);
        repeat (48) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        wait_done(120, seen);
        check("abort_no_done", 64'(seen), 64'd0);

        // Fresh run after the abort.
        run(pack8(300, -200, 50, 75, -400, 500, 25, -60));

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
